// File: rtl/spi_uart_pkg.sv
// -----------------------------------------------------------------------------
// spi_uart_pkg
// Shared definitions for the SPI/UART receive path.
//   DEFAULT_DATA_W : default width of the RX FIFO word
//   RD_LAT_MAX     : largest supported FIFO read latency (cycles)
//   arb_state_e    : states of the RX FIFO read-port arbiter
// -----------------------------------------------------------------------------
package spi_uart_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int RD_LAT_MAX     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a request and a non-empty FIFO
    READ = 2'd1,  // one-cycle FIFO pop strobe
    WAIT = 2'd2,  // waiting out the FIFO read latency
    DONE = 2'd3   // one-cycle ready pulse to the winner
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin picker.
// Ports:
//   req         in  [1:0]  request bits
//   last_served in         index of the requester served most recently
//   winner      out [1:0]  one-hot winner, all-zero when nobody requests
// A lone requester always wins; on a tie the requester that was not served
// last wins.
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic [1:0] winner
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    winner = 2'b00;
    unique case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = last_served ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase
  end

endmodule

// File: rtl/rx_fifo_arb.sv
// -----------------------------------------------------------------------------
// rx_fifo_arb
// Shares the read port of the RX FIFO between two requesters (bit0 = SPI
// control-register path, bit1 = loopback/debug path). Each service pops one
// word, waits RD_LAT cycles for the FIFO data, captures it and pulses ready
// to the winner for one cycle. Service period is 3 + RD_LAT cycles.
// Parameters:
//   DATA_W  FIFO word width
//   RD_LAT  cycles from rx_fifo_en to valid rx_fifo_data (1..RD_LAT_MAX)
// Ports:
//   clk            in                  rising-edge clock
//   rst            in                  synchronous active-high reset
//   req            in  [1:0]           level requests, held until ready
//   rd_data        out [DATA_W-1:0]    word for the granted requester
//   ready          out [1:0]           one-hot, one-cycle, rd_data valid
//   grant          out [1:0]           one-hot owner of the read port
//   rx_fifo_data   in  [DATA_W-1:0]    FIFO read data
//   rx_fifo_empty  in                  FIFO empty flag
//   rx_fifo_en     out                 FIFO pop strobe
// -----------------------------------------------------------------------------
module rx_fifo_arb
  import spi_uart_pkg::*;
#(
  parameter int DATA_W = spi_uart_pkg::DEFAULT_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        ready,
  output logic [1:0]        grant,
  input  logic [DATA_W-1:0] rx_fifo_data,
  input  logic              rx_fifo_empty,
  output logic              rx_fifo_en
);

  localparam int CNT_W = $clog2(RD_LAT_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RD_LAT - 1);

  arb_state_e        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_q, last_d;     // 1 = requester 1 served last
  logic [CNT_W-1:0]  cnt_q, cnt_d;       // cycles spent in WAIT
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [1:0]        winner;

  rr_arb2 u_rr_arb2 (
    .req         (req),
    .last_served (last_q),
    .winner      (winner)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;

    unique case (state_q)
      IDLE: begin
        // The empty flag is only consulted here; once READ is entered the
        // transaction runs to completion whatever the flag does.
        if ((req != 2'b00) && !rx_fifo_empty) begin
          grant_d = winner;
          state_d = READ;
        end
      end
      READ: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == LAST_CNT) begin
          rd_data_d = rx_fifo_data;
          last_d    = grant_q[1];  // pointer moves as DONE is entered
          cnt_d     = '0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // The winner's req is not re-checked: a word already popped is
        // always delivered even if the requester has since dropped.
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of evaluation order.
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;   // requester 0 wins the first tie
      cnt_q     <= '0;
      // NOTE: the data register is reset too, so rd_data reads zero rather
      // than a stale or undefined word until the first capture.
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rx_fifo_en = (state_q == READ);
  assign ready      = (state_q == DONE) ? grant_q : 2'b00;
  assign grant      = grant_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_rx_fifo_arb.sv
// -----------------------------------------------------------------------------
// tb_rx_fifo_arb
// Drives two arbiters (RD_LAT = 1 and RD_LAT = 3) from the same requests and
// the same stream of pushed words. Each arbiter sees its own FIFO view: a
// shared word list with a private read pointer and a private read-latency
// pipeline. A transaction-level reference model schedules, for each service,
// the pop cycle, the ready cycle and the delivered word, and every cycle the
// DUT outputs are compared with that schedule. Directed scenarios add
// explicit timing/data checks on top.
// -----------------------------------------------------------------------------
module tb_rx_fifo_arb;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req = 2'b00;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic [1:0]    ready_a, ready_b, grant_a, grant_b;
  logic [DW-1:0] fdata_a = '0, fdata_b = '0;
  logic          empty_a = 1'b1, empty_b = 1'b1;
  logic          en_a, en_b;

  always #5 clk = ~clk;

  rx_fifo_arb #(.DATA_W(DW), .RD_LAT(1)) u_dut_a (
    .clk (clk), .rst (rst), .req (req),
    .rd_data (rd_data_a), .ready (ready_a), .grant (grant_a),
    .rx_fifo_data (fdata_a), .rx_fifo_empty (empty_a), .rx_fifo_en (en_a)
  );

  rx_fifo_arb #(.DATA_W(DW), .RD_LAT(3)) u_dut_b (
    .clk (clk), .rst (rst), .req (req),
    .rd_data (rd_data_b), .ready (ready_b), .grant (grant_b),
    .rx_fifo_data (fdata_b), .rx_fifo_empty (empty_b), .rx_fifo_en (en_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // FIFO environment
  logic [DW-1:0] words[$];
  logic [DW-1:0] push_pend[$];
  int            rd_ptr[2];
  logic [DW-1:0] pipe[2][4];
  bit            en_seen[2];
  logic          rst_drv = 1'b1;
  logic [1:0]    req_drv = 2'b00;

  // reference model (one service schedule per DUT)
  bit            m_busy[2];
  int            m_en_at[2];
  int            m_rdy_at[2];
  logic [1:0]    m_win[2];
  bit            m_last[2];
  logic [DW-1:0] m_word[2];
  logic [DW-1:0] m_data[2];

  // observation log for directed checks
  int            en_cnt[2];
  int            last_en_cyc[2];
  int            rdy_cnt[2];
  int            last_rdy_cyc[2];
  logic [1:0]    last_rdy_who[2];
  logic [DW-1:0] last_rdy_dat[2];
  int            log_cyc[$];
  logic [1:0]    log_who[$];
  logic [DW-1:0] log_dat[$];

  function automatic int lat(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic clear_logs();
    for (int i = 0; i < 2; i++) begin
      en_cnt[i] = 0; last_en_cyc[i] = -1;
      rdy_cnt[i] = 0; last_rdy_cyc[i] = -1;
      last_rdy_who[i] = 2'b00; last_rdy_dat[i] = '0;
    end
    log_cyc.delete(); log_who.delete(); log_dat.delete();
  endtask

  // One clock cycle: update FIFO views and inputs after the edge, then
  // compare outputs against the model at the falling edge.
  task automatic step();
    logic [DW-1:0] popped;
    logic          en_o, e_en;
    logic [1:0]    rdy_o, gnt_o, e_rdy, e_gnt;
    logic [DW-1:0] rd_o;
    bit            empty_now;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      popped = DW'($urandom);
      if (en_seen[i] && rd_ptr[i] < words.size()) begin
        popped = words[rd_ptr[i]];
        rd_ptr[i]++;
      end
      for (int k = 3; k > 0; k--) pipe[i][k] = pipe[i][k-1];
      pipe[i][0] = popped;
    end
    while (push_pend.size() > 0) words.push_back(push_pend.pop_front());
    rst     = rst_drv;
    req     = req_drv;
    fdata_a = pipe[0][lat(0)-1];
    fdata_b = pipe[1][lat(1)-1];
    empty_a = (rd_ptr[0] >= words.size());
    empty_b = (rd_ptr[1] >= words.size());
    cyc++;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      en_o  = (i == 0) ? en_a      : en_b;
      rdy_o = (i == 0) ? ready_a   : ready_b;
      gnt_o = (i == 0) ? grant_a   : grant_b;
      rd_o  = (i == 0) ? rd_data_a : rd_data_b;
      empty_now = (i == 0) ? empty_a : empty_b;
      en_seen[i] = (en_o === 1'b1);
      if (en_seen[i]) begin
        en_cnt[i]++;
        last_en_cyc[i] = cyc;
      end
      if ((|rdy_o) === 1'b1) begin
        rdy_cnt[i]++;
        last_rdy_cyc[i] = cyc;
        last_rdy_who[i] = rdy_o;
        last_rdy_dat[i] = rd_o;
        if (i == 0) begin
          log_cyc.push_back(cyc); log_who.push_back(rdy_o); log_dat.push_back(rd_o);
        end
      end

      // expectations for this cycle
      e_en  = m_busy[i] && (cyc == m_en_at[i]);
      e_rdy = (m_busy[i] && cyc == m_rdy_at[i]) ? m_win[i] : 2'b00;
      e_gnt = (m_busy[i] && cyc >= m_en_at[i] && cyc <= m_rdy_at[i]) ? m_win[i] : 2'b00;
      if (m_busy[i] && cyc == m_rdy_at[i]) m_data[i] = m_word[i];

      if (chk_en) begin
        n_cmp++;
        if (en_o !== e_en) begin
          n_bad++;
          $display("FAIL rx_fifo_en dut%0d cyc %0d: got %b want %b", i, cyc, en_o, e_en);
        end
        n_cmp++;
        if (rdy_o !== e_rdy) begin
          n_bad++;
          $display("FAIL ready dut%0d cyc %0d: got %b want %b", i, cyc, rdy_o, e_rdy);
        end
        n_cmp++;
        if (gnt_o !== e_gnt) begin
          n_bad++;
          $display("FAIL grant dut%0d cyc %0d: got %b want %b", i, cyc, gnt_o, e_gnt);
        end
        n_cmp++;
        if (rd_o !== m_data[i]) begin
          n_bad++;
          $display("FAIL rd_data dut%0d cyc %0d: got %h want %h", i, cyc, rd_o, m_data[i]);
        end
      end

      // advance the model
      if (rst === 1'b1) begin
        m_busy[i] = 1'b0;
        m_last[i] = 1'b1;
        m_data[i] = '0;
      end else if (m_busy[i] && cyc == m_rdy_at[i]) begin
        m_busy[i] = 1'b0;
      end else if (!m_busy[i] && req != 2'b00 && !empty_now) begin
        if (req == 2'b11) m_win[i] = m_last[i] ? 2'b01 : 2'b10;
        else              m_win[i] = req;
        m_last[i]   = m_win[i][1];
        m_en_at[i]  = cyc + 1;
        m_rdy_at[i] = cyc + 2 + lat(i);
        m_word[i]   = words[rd_ptr[i]];
        m_busy[i]   = 1'b1;
      end
    end
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Two reset cycles with the FIFO flushed; logs start afresh.
  task automatic do_reset();
    rst_drv = 1'b1;
    push_pend.delete();
    for (int i = 0; i < 2; i++) rd_ptr[i] = words.size();
    step();
    chk_en = 1'b1;
    step();
    rst_drv = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    int t0;
    req_drv = 2'b01;
    rst_drv = 1'b1;
    for (int i = 0; i < 2; i++) rd_ptr[i] = words.size();
    step();
    chk_en = 1'b1;
    push_pend.push_back(16'h1234);
    step();
    n_cmp++;
    if ({ready_a, grant_a, en_a, rd_data_a} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b gnt=%b en=%b data=%h want all zero",
               ready_a, grant_a, en_a, rd_data_a);
    end
    rst_drv = 1'b0;
    clear_logs();
    t0 = cyc + 1;
    run(8);
    n_cmp++;
    if (last_en_cyc[0] !== t0 + 1 || en_cnt[0] !== 1) begin
      n_bad++;
      $display("FAIL first_pop: got cyc %0d count %0d want cyc %0d count 1",
               last_en_cyc[0] - t0, en_cnt[0], 1);
    end
    n_cmp++;
    if (last_rdy_cyc[0] !== t0 + 3 || last_rdy_who[0] !== 2'b01 || last_rdy_dat[0] !== 16'h1234) begin
      n_bad++;
      $display("FAIL first_ready: got cyc %0d who %b data %h want cyc 3 who 01 data 1234",
               last_rdy_cyc[0] - t0, last_rdy_who[0], last_rdy_dat[0]);
    end
    n_cmp++;
    if (last_rdy_cyc[1] !== t0 + 5 || last_rdy_dat[1] !== 16'h1234 || last_en_cyc[1] !== t0 + 1) begin
      n_bad++;
      $display("FAIL lat3_ready: got en %0d rdy %0d data %h want en 1 rdy 5 data 1234",
               last_en_cyc[1] - t0, last_rdy_cyc[1] - t0, last_rdy_dat[1]);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]    w_who[3] = '{2'b01, 2'b10, 2'b01};
    logic [DW-1:0] w_dat[3] = '{16'hA001, 16'hA002, 16'hA003};
    req_drv = 2'b11;
    do_reset();
    for (int k = 0; k < 3; k++) push_pend.push_back(w_dat[k]);
    run(24);
    req_drv = 2'b00;
    run(4);
    n_cmp++;
    if (log_cyc.size() !== 3) begin
      n_bad++;
      $display("FAIL rr_count: got %0d pulses want 3", log_cyc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (log_who[k] !== w_who[k] || log_dat[k] !== w_dat[k]) begin
          n_bad++;
          $display("FAIL rr_order[%0d]: got %b/%h want %b/%h", k, log_who[k], log_dat[k],
                   w_who[k], w_dat[k]);
        end
      end
      for (int k = 1; k < 3; k++) begin
        n_cmp++;
        if (log_cyc[k] - log_cyc[k-1] !== 4) begin
          n_bad++;
          $display("FAIL rr_period[%0d]: got %0d want 4", k, log_cyc[k] - log_cyc[k-1]);
        end
      end
    end
  endtask

  task automatic test_empty_wait();
    int e;
    req_drv = 2'b10;
    do_reset();
    run(20);
    n_cmp++;
    if (en_cnt[0] + en_cnt[1] !== 0) begin
      n_bad++;
      $display("FAIL pop_while_empty: got %0d pops want 0", en_cnt[0] + en_cnt[1]);
    end
    push_pend.push_back(16'h00FF);
    step();
    e = cyc;
    run(8);
    req_drv = 2'b00;
    n_cmp++;
    if (last_rdy_cyc[0] !== e + 3 || last_rdy_who[0] !== 2'b10 || last_rdy_dat[0] !== 16'h00FF) begin
      n_bad++;
      $display("FAIL empty_release: got +%0d who %b data %h want +3 who 10 data 00ff",
               last_rdy_cyc[0] - e, last_rdy_who[0], last_rdy_dat[0]);
    end
  endtask

  task automatic test_drop_and_reset();
    int p0;
    req_drv = 2'b00;
    do_reset();
    p0 = rd_ptr[0];
    req_drv = 2'b01;
    push_pend.push_back(16'hBEEF);
    push_pend.push_back(16'h5A5A);
    run(2);             // IDLE decision, READ
    req_drv = 2'b00;    // drops while WAIT runs
    run(6);
    n_cmp++;
    if (rdy_cnt[0] !== 1 || last_rdy_who[0] !== 2'b01 || last_rdy_dat[0] !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL drop_ready: got %0d pulses who %b data %h want 1 01 beef",
               rdy_cnt[0], last_rdy_who[0], last_rdy_dat[0]);
    end
    n_cmp++;
    if (rd_ptr[0] - p0 !== 1) begin
      n_bad++;
      $display("FAIL drop_pop_count: got %0d want 1", rd_ptr[0] - p0);
    end
    clear_logs();
    req_drv = 2'b01;
    run(2);             // IDLE decision, READ (pops 5A5A)
    req_drv = 2'b00;
    rst_drv = 1'b1;
    step();             // WAIT with reset sampled at its end
    rst_drv = 1'b0;
    step();
    n_cmp++;
    if ({ready_a, grant_a, en_a, rd_data_a} !== '0) begin
      n_bad++;
      $display("FAIL abort_outputs: got rdy=%b gnt=%b en=%b data=%h want all zero",
               ready_a, grant_a, en_a, rd_data_a);
    end
    run(6);
    n_cmp++;
    if (rdy_cnt[0] + rdy_cnt[1] !== 0) begin
      n_bad++;
      $display("FAIL abort_ready: got %0d pulses want 0", rdy_cnt[0] + rdy_cnt[1]);
    end
  endtask

  task automatic test_random();
    req_drv = 2'b00;
    do_reset();
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 3) == 0) req_drv = 2'($urandom);
      if ($urandom_range(0, 2) == 0) push_pend.push_back(DW'($urandom));
      rst_drv = ($urandom_range(0, 149) == 0);
      step();
    end
    rst_drv = 1'b0;
    req_drv = 2'b00;
    run(10);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rd_ptr[i] = 0; en_seen[i] = 1'b0; m_busy[i] = 1'b0;
      m_last[i] = 1'b1; m_data[i] = '0; m_word[i] = '0; m_win[i] = 2'b00;
      m_en_at[i] = -1; m_rdy_at[i] = -1;
      for (int k = 0; k < 4; k++) pipe[i][k] = '0;
    end
    clear_logs();
    test_reset();
    test_round_robin();
    test_empty_wait();
    test_drop_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
